// File: rtl/e203_exu_fpu_wbck.sv
// FPU writeback arbiter: fixed-priority merge of long-pipe, load and short-pipe
// results onto the single regfile write port, plus the long-pipe busy scoreboard.
module e203_exu_fpu_wbck #(
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5,
  parameter int RFREG_NUM   = 32
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   alu_wbck_i_valid,
  output logic                   alu_wbck_i_ready,
  input  logic [RFIDX_WIDTH-1:0] alu_wbck_i_idx,
  input  logic [XLEN-1:0]        alu_wbck_i_dat,

  input  logic                   lsu_wbck_i_valid,
  output logic                   lsu_wbck_i_ready,
  input  logic [RFIDX_WIDTH-1:0] lsu_wbck_i_idx,
  input  logic [XLEN-1:0]        lsu_wbck_i_dat,

  input  logic                   lng_wbck_i_valid,
  output logic                   lng_wbck_i_ready,
  input  logic [RFIDX_WIDTH-1:0] lng_wbck_i_idx,
  input  logic [XLEN-1:0]        lng_wbck_i_dat,

  input  logic                   lng_issue_valid,
  input  logic [RFIDX_WIDTH-1:0] lng_issue_idx,

  output logic                   wbck_dest_wen,
  output logic [RFIDX_WIDTH-1:0] wbck_dest_idx,
  output logic [XLEN-1:0]        wbck_dest_dat,
  output logic [RFREG_NUM-1:0]   rf_busy,
  output logic                   wbck_err
);

  logic                   w_grant;
  logic [RFIDX_WIDTH-1:0] w_sel_idx;
  logic [XLEN-1:0]        w_sel_dat;
  logic [RFREG_NUM-1:0]   w_set;
  logic [RFREG_NUM-1:0]   w_clr;
  logic                   w_err_issue;
  logic                   w_err_wbck;

  logic                   r_wen;
  logic [RFIDX_WIDTH-1:0] r_idx;
  logic [XLEN-1:0]        r_dat;
  logic [RFREG_NUM-1:0]   r_busy;
  logic                   r_err;

  // Regfile never stalls, so the ready of the winning source is the handshake.
  always_comb begin
    lng_wbck_i_ready = 1'b0;
    lsu_wbck_i_ready = 1'b0;
    alu_wbck_i_ready = 1'b0;
    w_sel_idx        = alu_wbck_i_idx;
    w_sel_dat        = alu_wbck_i_dat;
    if (!rst) begin
      if (lng_wbck_i_valid) begin
        lng_wbck_i_ready = 1'b1;
        w_sel_idx        = lng_wbck_i_idx;
        w_sel_dat        = lng_wbck_i_dat;
      end else if (lsu_wbck_i_valid) begin
        lsu_wbck_i_ready = 1'b1;
        w_sel_idx        = lsu_wbck_i_idx;
        w_sel_dat        = lsu_wbck_i_dat;
      end else if (alu_wbck_i_valid) begin
        alu_wbck_i_ready = 1'b1;
      end
    end
    w_grant = lng_wbck_i_ready | lsu_wbck_i_ready | alu_wbck_i_ready;
  end

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (lng_issue_valid)  w_set = RFREG_NUM'(1) << lng_issue_idx;
    if (lng_wbck_i_ready) w_clr = RFREG_NUM'(1) << lng_wbck_i_idx;
    w_err_issue = lng_issue_valid & r_busy[lng_issue_idx] & ~w_clr[lng_issue_idx];
    w_err_wbck  = lng_wbck_i_ready & ~r_busy[lng_wbck_i_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wen  <= 1'b0;
      r_idx  <= '0;
      r_dat  <= '0;
      r_busy <= '0;
      r_err  <= 1'b0;
    end else begin
      r_wen <= w_grant;
      if (w_grant) begin
        r_idx <= w_sel_idx;
        r_dat <= w_sel_dat;
      end
      // Set is applied after clear so a same-index reissue keeps the bit.
      r_busy <= (r_busy & ~w_clr) | w_set;
      if (w_err_issue || w_err_wbck) r_err <= 1'b1;
    end
  end

  assign wbck_dest_wen = r_wen;
  assign wbck_dest_idx = r_idx;
  assign wbck_dest_dat = r_dat;
  assign rf_busy       = r_busy;
  assign wbck_err      = r_err;

endmodule

// File: tb/tb_e203_exu_fpu_wbck.sv
// Directed bench for e203_exu_fpu_wbck: arbitration, output latency, scoreboard and error flag.
module tb_e203_exu_fpu_wbck;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_v, lsu_v, lng_v;
  logic        alu_r, lsu_r, lng_r;
  logic [4:0]  alu_i, lsu_i, lng_i;
  logic [31:0] alu_d, lsu_d, lng_d;
  logic        iss_v;
  logic [4:0]  iss_i;
  logic        wen;
  logic [4:0]  widx;
  logic [31:0] wdat;
  logic [31:0] busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  e203_exu_fpu_wbck #(.XLEN(32), .RFIDX_WIDTH(5), .RFREG_NUM(32)) dut (
    .clk(clk), .rst(rst),
    .alu_wbck_i_valid(alu_v), .alu_wbck_i_ready(alu_r), .alu_wbck_i_idx(alu_i), .alu_wbck_i_dat(alu_d),
    .lsu_wbck_i_valid(lsu_v), .lsu_wbck_i_ready(lsu_r), .lsu_wbck_i_idx(lsu_i), .lsu_wbck_i_dat(lsu_d),
    .lng_wbck_i_valid(lng_v), .lng_wbck_i_ready(lng_r), .lng_wbck_i_idx(lng_i), .lng_wbck_i_dat(lng_d),
    .lng_issue_valid(iss_v), .lng_issue_idx(iss_i),
    .wbck_dest_wen(wen), .wbck_dest_idx(widx), .wbck_dest_dat(wdat),
    .rf_busy(busy), .wbck_err(err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; alu_v = 0; lsu_v = 0; lng_v = 0; iss_v = 0;
    alu_i = 0; lsu_i = 0; lng_i = 0; iss_i = 0; alu_d = 0; lsu_d = 0; lng_d = 0;
    alu_v = 1'b1; alu_i = 5'd3; alu_d = 32'h1234_5678;
    step(); step();
    checks++; if (alu_r !== 1'b0) begin errors++; $display("FAIL rst_alu_ready got=%b exp=0", alu_r); end
    checks++; if (wen !== 1'b0) begin errors++; $display("FAIL rst_wen got=%b exp=0", wen); end
    checks++; if (widx !== 5'd0) begin errors++; $display("FAIL rst_idx got=%0d exp=0", widx); end
    checks++; if (wdat !== 32'h0) begin errors++; $display("FAIL rst_dat got=%h exp=0", wdat); end
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL rst_busy got=%h exp=0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", err); end
    alu_v = 1'b0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_alu_single();
    alu_v = 1'b1; alu_i = 5'd3; alu_d = 32'h3F80_0000;
    #1;
    checks++; if ({lng_r, lsu_r, alu_r} !== 3'b001) begin errors++; $display("FAIL alu_ready got=%b exp=001", {lng_r, lsu_r, alu_r}); end
    step(); alu_v = 1'b0;
    checks++; if ({wen, widx, wdat} !== {1'b1, 5'd3, 32'h3F80_0000}) begin errors++; $display("FAIL alu_write got=%b/%0d/%h exp=1/3/3f800000", wen, widx, wdat); end
    step();
    checks++; if ({wen, widx, wdat} !== {1'b0, 5'd3, 32'h3F80_0000}) begin errors++; $display("FAIL alu_idle got=%b/%0d/%h exp=0/3/3f800000", wen, widx, wdat); end
  endtask

  task automatic test_priority();
    iss_v = 1'b1; iss_i = 5'd4; step(); iss_v = 1'b0;
    alu_v = 1; alu_i = 5'd1; alu_d = 32'hAAAA_0001;
    lsu_v = 1; lsu_i = 5'd2; lsu_d = 32'hBBBB_0002;
    lng_v = 1; lng_i = 5'd4; lng_d = 32'hCCCC_0004;
    #1;
    checks++; if ({lng_r, lsu_r, alu_r} !== 3'b100) begin errors++; $display("FAIL prio_lng got=%b exp=100", {lng_r, lsu_r, alu_r}); end
    step(); lng_v = 0; #1;
    checks++; if ({wen, widx, wdat} !== {1'b1, 5'd4, 32'hCCCC_0004}) begin errors++; $display("FAIL prio_w1 got=%b/%0d/%h exp=1/4/cccc0004", wen, widx, wdat); end
    checks++; if ({lng_r, lsu_r, alu_r} !== 3'b010) begin errors++; $display("FAIL prio_lsu got=%b exp=010", {lng_r, lsu_r, alu_r}); end
    step(); lsu_v = 0;
    checks++; if ({wen, widx, wdat} !== {1'b1, 5'd2, 32'hBBBB_0002}) begin errors++; $display("FAIL prio_w2 got=%b/%0d/%h exp=1/2/bbbb0002", wen, widx, wdat); end
    step(); alu_v = 0;
    checks++; if ({wen, widx, wdat} !== {1'b1, 5'd1, 32'hAAAA_0001}) begin errors++; $display("FAIL prio_w3 got=%b/%0d/%h exp=1/1/aaaa0001", wen, widx, wdat); end
    step(); #1;
    checks++; if ({wen, lng_r, lsu_r, alu_r} !== 4'b0000) begin errors++; $display("FAIL prio_idle got=%b exp=0000", {wen, lng_r, lsu_r, alu_r}); end
    checks++; if ({busy, err} !== 33'h0) begin errors++; $display("FAIL prio_sb got=%h/%b exp=0/0", busy, err); end
  endtask

  task automatic test_scoreboard();
    iss_v = 1; iss_i = 5'd7; step(); iss_v = 0;
    checks++; if (busy !== 32'h80) begin errors++; $display("FAIL sb_set got=%h exp=80", busy); end
    for (int i = 0; i < 4; i++) step();
    lng_v = 1; lng_i = 5'd7; lng_d = 32'h4000_0000;
    step(); lng_v = 0;
    checks++; if ({busy, wen, widx, wdat} !== {32'h0, 1'b1, 5'd7, 32'h4000_0000}) begin errors++; $display("FAIL sb_clr got=%h/%b/%0d/%h exp=0/1/7/40000000", busy, wen, widx, wdat); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL sb_err got=%b exp=0", err); end
  endtask

  task automatic test_set_clear_same();
    iss_v = 1; iss_i = 5'd7; step();
    lng_v = 1; lng_i = 5'd7; lng_d = 32'h4040_0000;
    step(); iss_v = 0; lng_v = 0;
    checks++; if ({busy, wen, widx, err} !== {32'h80, 1'b1, 5'd7, 1'b0}) begin errors++; $display("FAIL same_idx got=%h/%b/%0d/%b exp=80/1/7/0", busy, wen, widx, err); end
    lng_v = 1; lng_d = 32'h4080_0000; step(); lng_v = 0;
    checks++; if ({busy, err} !== {32'h0, 1'b0}) begin errors++; $display("FAIL same_drain got=%h/%b exp=0/0", busy, err); end
  endtask

  task automatic test_set_clear_diff();
    iss_v = 1; iss_i = 5'd3; step();
    iss_i = 5'd6; lng_v = 1; lng_i = 5'd3; lng_d = 32'h0000_0033;
    step(); iss_v = 0; lng_v = 0;
    checks++; if ({busy, err, widx} !== {32'h40, 1'b0, 5'd3}) begin errors++; $display("FAIL diff_idx got=%h/%b/%0d exp=40/0/3", busy, err, widx); end
    lng_v = 1; lng_i = 5'd6; step(); lng_v = 0;
    checks++; if ({busy, err} !== {32'h0, 1'b0}) begin errors++; $display("FAIL diff_drain got=%h/%b exp=0/0", busy, err); end
  endtask

  task automatic test_err();
    iss_v = 1; iss_i = 5'd5; step(); step(); iss_v = 0;
    checks++; if ({busy, err} !== {32'h20, 1'b1}) begin errors++; $display("FAIL err_dbl_issue got=%h/%b exp=20/1", busy, err); end
    step(); step();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", err); end
    rst = 1; step(); rst = 0;
    checks++; if ({busy, err} !== 33'h0) begin errors++; $display("FAIL err_rst1 got=%h/%b exp=0/0", busy, err); end
    lng_v = 1; lng_i = 5'd9; lng_d = 32'h0000_0099; step(); lng_v = 0;
    checks++; if ({err, wen, widx, busy} !== {1'b1, 1'b1, 5'd9, 32'h0}) begin errors++; $display("FAIL err_not_busy got=%b/%b/%0d/%h exp=1/1/9/0", err, wen, widx, busy); end
    rst = 1; step(); rst = 0;
    checks++; if ({wen, widx, wdat, busy, err} !== '0) begin errors++; $display("FAIL err_rst2 got=%b/%0d/%h/%h/%b exp=all0", wen, widx, wdat, busy, err); end
  endtask

  task automatic test_reset_mid();
    lsu_v = 1; lsu_i = 5'd10; lsu_d = 32'hDEAD_BEEF; iss_v = 1; iss_i = 5'd12;
    rst = 1; #1;
    checks++; if (lsu_r !== 1'b0) begin errors++; $display("FAIL mid_ready got=%b exp=0", lsu_r); end
    step(); iss_v = 0;
    checks++; if ({wen, busy} !== 33'h0) begin errors++; $display("FAIL mid_drop got=%b/%h exp=0/0", wen, busy); end
    rst = 0; #1;
    checks++; if (lsu_r !== 1'b1) begin errors++; $display("FAIL mid_regrant got=%b exp=1", lsu_r); end
    step(); lsu_v = 0;
    checks++; if ({wen, widx, wdat} !== {1'b1, 5'd10, 32'hDEAD_BEEF}) begin errors++; $display("FAIL mid_write got=%b/%0d/%h exp=1/10/deadbeef", wen, widx, wdat); end
  endtask

  initial begin
    test_reset();
    test_alu_single();
    test_priority();
    test_scoreboard();
    test_set_clear_same();
    test_set_clear_diff();
    test_err();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
